// File: rtl/axis_rr_pkt_merger.sv
// N-input AXI-Stream packet merger: round-robin grant at packet boundaries, one output register stage.
// Define MERGER_PKT_CNT_EN to add per-channel completed-packet counters on pkt_cnt.
module axis_rr_pkt_merger #(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned USER_W = 48,
  parameter int unsigned DEST_W = 4
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       enable,
  input  logic [N_CH-1:0]            s_axis_tvalid,
  output logic [N_CH-1:0]            s_axis_tready,
  input  logic [N_CH*DATA_W-1:0]     s_axis_tdata,
  input  logic [N_CH*(DATA_W/8)-1:0] s_axis_tkeep,
  input  logic [N_CH*USER_W-1:0]     s_axis_tuser,
  input  logic [N_CH-1:0]            s_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [DATA_W-1:0]          m_axis_tdata,
  output logic [DATA_W/8-1:0]        m_axis_tkeep,
  output logic [USER_W-1:0]          m_axis_tuser,
  output logic                       m_axis_tlast,
  output logic [DEST_W-1:0]          m_axis_tdest
`ifdef MERGER_PKT_CNT_EN
  ,
  output logic [N_CH*32-1:0]         pkt_cnt
`endif
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;

  logic [IDX_W-1:0]   idx_c;
  logic [IDX_W-1:0]   cand_c;
  logic               cand_vld_c;
  logic [IDX_W-1:0]   sel_c;
  logic               sel_vld_c;
  logic               load_c;
  logic               hs_c;
  logic               hs_last_c;

  logic               m_valid_q;
  logic [DATA_W-1:0]  m_data_q;
  logic [KEEP_W-1:0]  m_keep_q;
  logic [USER_W-1:0]  m_user_q;
  logic               m_last_q;
  logic [DEST_W-1:0]  m_dest_q;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = (32'(base) + off) % N_CH;
    return IDX_W'(s);
  endfunction

  // Round-robin candidate: first valid channel after last_q, scanned in reverse so the nearest wins.
  always_comb begin
    idx_c      = '0;
    cand_c     = '0;
    cand_vld_c = 1'b0;
    for (int unsigned i = N_CH; i >= 1; i--) begin
      idx_c = wrap_idx(last_q, i);
      if (s_axis_tvalid[idx_c]) begin
        cand_c     = idx_c;
        cand_vld_c = 1'b1;
      end
    end
  end

  // Output decode: grant select, per-channel ready and handshake strobes.
  always_comb begin
    load_c        = ~m_valid_q | m_axis_tready;
    sel_c         = cand_c;
    sel_vld_c     = enable & cand_vld_c;
    s_axis_tready = '0;
    if (state_q == ST_LOCKED) begin
      sel_c     = grant_q;
      sel_vld_c = 1'b1;
    end
    if (sel_vld_c && load_c && aresetn) begin
      s_axis_tready[sel_c] = 1'b1;
    end
    hs_c      = sel_vld_c & load_c & aresetn & s_axis_tvalid[sel_c];
    hs_last_c = hs_c & s_axis_tlast[sel_c];
  end

  // Next state: lock onto a channel after a non-final first beat, release on its tlast beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_c) begin
          last_d  = sel_c;
          grant_d = sel_c;
          if (!hs_last_c) begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_LOCKED: begin
        if (hs_last_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_CH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  // Output register; payload only reloads on an accepted beat so a stalled beat stays put.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_user_q  <= '0;
      m_last_q  <= 1'b0;
      m_dest_q  <= '0;
    end else if (load_c) begin
      m_valid_q <= hs_c;
      if (hs_c) begin
        m_data_q <= s_axis_tdata[32'(sel_c) * DATA_W +: DATA_W];
        m_keep_q <= s_axis_tkeep[32'(sel_c) * KEEP_W +: KEEP_W];
        m_user_q <= s_axis_tuser[32'(sel_c) * USER_W +: USER_W];
        m_last_q <= s_axis_tlast[sel_c];
        m_dest_q <= DEST_W'(sel_c);
      end
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tdest  = m_dest_q;

`ifdef MERGER_PKT_CNT_EN
  logic [31:0] cnt_q [N_CH];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        cnt_q[c] <= '0;
      end
    end else if (hs_last_c) begin
      cnt_q[sel_c] <= cnt_q[sel_c] + 32'd1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign pkt_cnt[g*32 +: 32] = cnt_q[g];
  end
`endif

endmodule
